rom_load_sequencer: RTL and testbench

- Sits between the HPS download stream (ioctl_*) and the Williams core's ROM/PROM write ports.
- Decodes each downloaded byte into one of three regions (main CPU ROM, sound ROM, decoder PROM) and rebases its address.
- Checks that the download is contiguous and the expected length.
- Sequences the core reset: held during load, held for a fixed settle period afterwards, released only after a valid image.

---
 rtl/williams_pkg.sv | 27 ++
 rtl/rom_region_dec.sv | 37 +++
 rtl/rom_load_sequencer.sv | 146 ++++++++++++++
 tb/tb_rom_load_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/williams_pkg.sv
// Shared types and default memory map for the Williams ROM download path.
package williams_pkg;

    localparam int unsigned DL_ADDR_W  = 25;
    localparam int unsigned ROM_ADDR_W = 16;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned HOLD_W     = 16;

    localparam logic [ROM_ADDR_W-1:0] MAIN_END_DEF = 16'hC000;
    localparam logic [ROM_ADDR_W-1:0] SND_END_DEF  = 16'hD000;
    localparam logic [ROM_ADDR_W-1:0] PROM_END_DEF = 16'hD200;
    localparam int unsigned           HOLD_DEF     = 256;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        HOLD  = 2'd2,
        RUN   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        REG_MAIN = 2'd0,
        REG_SND  = 2'd1,
        REG_PROM = 2'd2
    } region_e;

endpackage

// File: rtl/rom_region_dec.sv
// Combinational image-address decode: region select, region-relative address
// and an out-of-image flag.
module rom_region_dec
    import williams_pkg::*;
#(
    parameter logic [ROM_ADDR_W-1:0] MAIN_END = MAIN_END_DEF,
    parameter logic [ROM_ADDR_W-1:0] SND_END  = SND_END_DEF,
    parameter logic [ROM_ADDR_W-1:0] PROM_END = PROM_END_DEF
) (
    input  logic [DL_ADDR_W-1:0]  addr,
    output region_e               sel_c,
    output logic [ROM_ADDR_W-1:0] rebased_c,
    output logic                  overflow_c
);

    logic [ROM_ADDR_W-1:0] low;

    assign low = addr[ROM_ADDR_W-1:0];

    // Any set bit above 16 is past the image no matter what the low half says.
    always_comb begin
        sel_c      = REG_MAIN;
        rebased_c  = low;
        overflow_c = (addr[DL_ADDR_W-1:ROM_ADDR_W] != '0) || (low >= PROM_END);
        if (low < MAIN_END) begin
            sel_c     = REG_MAIN;
            rebased_c = low;
        end else if (low < SND_END) begin
            sel_c     = REG_SND;
            rebased_c = low - MAIN_END;
        end else begin
            sel_c     = REG_PROM;
            rebased_c = low - SND_END;
        end
    end

endmodule

// File: rtl/rom_load_sequencer.sv
// Routes HPS download bytes to the core ROM/PROM write ports, validates the
// image and sequences the core reset around loads and user resets.
module rom_load_sequencer
    import williams_pkg::*;
#(
    parameter logic [ROM_ADDR_W-1:0] MAIN_END    = MAIN_END_DEF,
    parameter logic [ROM_ADDR_W-1:0] SND_END     = SND_END_DEF,
    parameter logic [ROM_ADDR_W-1:0] PROM_END    = PROM_END_DEF,
    parameter int unsigned           HOLD_CYCLES = HOLD_DEF
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  dl_active,
    input  logic                  dl_wr,
    input  logic [DL_ADDR_W-1:0]  dl_addr,
    input  logic [DATA_W-1:0]     dl_data,
    input  logic                  user_reset,
    output logic                  rom_wr,
    output logic [1:0]            rom_sel,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0]     rom_data,
    output logic                  core_reset,
    output logic                  load_done,
    output logic                  load_err
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_e                 state;
    logic [DL_ADDR_W-1:0]   byte_cnt;
    logic                   err_flag;
    logic [HOLD_W-1:0]      hold_cnt;

    region_e                dec_sel;
    logic [ROM_ADDR_W-1:0]  dec_addr;
    logic                   dec_ovf;

    logic [DL_ADDR_W-1:0]   cnt_nxt;
    logic                   err_nxt;
    logic                   image_ok;

    rom_region_dec #(
        .MAIN_END (MAIN_END),
        .SND_END  (SND_END),
        .PROM_END (PROM_END)
    ) u_dec (
        .addr       (dl_addr),
        .sel_c      (dec_sel),
        .rebased_c  (dec_addr),
        .overflow_c (dec_ovf)
    );

    // Counter/error state including the current byte, so a strobe coincident
    // with the end of download is part of the size check.
    always_comb begin
        cnt_nxt = byte_cnt;
        err_nxt = err_flag;
        if (dl_wr) begin
            if (byte_cnt != '1) begin
                cnt_nxt = byte_cnt + DL_ADDR_W'(1);
            end
            if ((dl_addr != byte_cnt) || dec_ovf) begin
                err_nxt = 1'b1;
            end
        end
        image_ok = !err_nxt && (cnt_nxt == DL_ADDR_W'(PROM_END));
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            byte_cnt   <= '0;
            err_flag   <= 1'b0;
            hold_cnt   <= '0;
            rom_wr     <= 1'b0;
            rom_sel    <= 2'd0;
            rom_addr   <= '0;
            rom_data   <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            rom_wr <= 1'b0;
            // A new download preempts every other state.
            if (dl_active && (state != LOAD)) begin
                state      <= LOAD;
                byte_cnt   <= '0;
                err_flag   <= 1'b0;
                core_reset <= 1'b1;
                load_done  <= 1'b0;
                load_err   <= 1'b0;
            end else begin
                case (state)
                    EMPTY: begin
                        core_reset <= 1'b1;
                    end
                    LOAD: begin
                        core_reset <= 1'b1;
                        byte_cnt   <= cnt_nxt;
                        err_flag   <= err_nxt;
                        if (dl_wr && !dec_ovf) begin
                            rom_wr   <= 1'b1;
                            rom_sel  <= dec_sel;
                            rom_addr <= dec_addr;
                            rom_data <= dl_data;
                        end
                        if (!dl_active) begin
                            if (image_ok) begin
                                load_done <= 1'b1;
                                hold_cnt  <= '0;
                                state     <= HOLD;
                            end else begin
                                load_err  <= 1'b1;
                                state     <= EMPTY;
                            end
                        end
                    end
                    HOLD: begin
                        core_reset <= 1'b1;
                        if (user_reset) begin
                            hold_cnt <= '0;
                        end else if (hold_cnt == HOLD_LAST) begin
                            core_reset <= 1'b0;
                            state      <= RUN;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    RUN: begin
                        core_reset <= 1'b0;
                        if (user_reset) begin
                            core_reset <= 1'b1;
                            hold_cnt   <= '0;
                            state      <= HOLD;
                        end
                    end
                    default: begin
                        core_reset <= 1'b1;
                        state      <= EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Scoreboard bench for rom_load_sequencer on a 1/16-scale memory map.
module tb_rom_load_sequencer;

    localparam int MAIN_E = 'h0C00;
    localparam int SND_E  = 'h0D00;
    localparam int PROM_E = 'h0D20;
    localparam int HOLD_N = 256;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        dl_active;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        user_reset;
    logic        rom_wr;
    logic [1:0]  rom_sel;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        core_reset;
    logic        load_done;
    logic        load_err;

    typedef struct {
        int          src;
        logic [1:0]  sel;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   passes   = 0;
    int   wr_count = 0;

    always #5 clk_sys = ~clk_sys;

    rom_load_sequencer #(
        .MAIN_END    (16'(MAIN_E)),
        .SND_END     (16'(SND_E)),
        .PROM_END    (16'(PROM_E)),
        .HOLD_CYCLES (HOLD_N)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .user_reset (user_reset),
        .rom_wr     (rom_wr),
        .rom_sel    (rom_sel),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t mk(input int a);
        exp_t e;
        e.src  = a;
        e.data = 8'(a) ^ 8'h5A;
        if (a < MAIN_E) begin
            e.sel = 2'd0; e.addr = 16'(a);
        end else if (a < SND_E) begin
            e.sel = 2'd1; e.addr = 16'(a - MAIN_E);
        end else begin
            e.sel = 2'd2; e.addr = 16'(a - SND_E);
        end
        return e;
    endfunction

    // Monitor: every rom_wr pops one expected write.
    always @(negedge clk_sys) begin
        if (rom_wr === 1'b1) begin
            wr_count++;
            if (sb.size() == 0) begin
                chk("unexpected_rom_wr", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_sel", int'(rom_sel), int'(e.sel));
                chk("wr_addr", int'(rom_addr), int'(e.addr));
                chk("wr_data", int'(rom_data), int'(e.data));
                if (e.src == 'h0BFF) begin
                    chk("spot_bff_sel", int'(rom_sel), 0);
                    chk("spot_bff_addr", int'(rom_addr), 'h0BFF);
                end
                if (e.src == 'h0C00) begin
                    chk("spot_c00_sel", int'(rom_sel), 1);
                    chk("spot_c00_addr", int'(rom_addr), 0);
                end
                if (e.src == 'h0D1F) begin
                    chk("spot_d1f_sel", int'(rom_sel), 2);
                    chk("spot_d1f_addr", int'(rom_addr), 'h1F);
                end
            end
        end
    end

    // Drives n strobes; addresses past skip_at jump by one. With fall_last the
    // final strobe coincides with dl_active dropping.
    task automatic do_load(input int n, input int skip_at, input bit fall_last);
        int a;
        @(negedge clk_sys) dl_active = 1'b1;
        @(negedge clk_sys);
        chk("entry_done_clr", int'(load_done), 0);
        chk("entry_err_clr", int'(load_err), 0);
        for (int i = 0; i < n; i++) begin
            a = (skip_at >= 0 && i > skip_at) ? i + 1 : i;
            dl_wr   = 1'b1;
            dl_addr = 25'(a);
            dl_data = 8'(a) ^ 8'h5A;
            if (a < PROM_E) sb.push_back(mk(a));
            if (fall_last && i == n - 1) dl_active = 1'b0;
            if (i != n - 1) @(negedge clk_sys);
        end
        if (!fall_last) begin
            @(negedge clk_sys);
            dl_wr     = 1'b0;
            dl_active = 1'b0;
        end
    endtask

    // Counts rising edges from the next one until core_reset is seen low.
    task automatic edges_to_release(output int n);
        n = 0;
        @(posedge clk_sys);
        #1;
        dl_wr      = 1'b0;
        user_reset = 1'b0;
        while (n < 2000) begin
            @(posedge clk_sys);
            n++;
            #1;
            if (core_reset == 1'b0) break;
        end
    endtask

    initial begin
        int n;
        int bad;
        reset_n    = 1'b0;
        dl_active  = 1'b0;
        dl_wr      = 1'b0;
        dl_addr    = '0;
        dl_data    = '0;
        user_reset = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_rom_wr", int'(rom_wr), 0);
        chk("rst_rom_sel", int'(rom_sel), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_rom_data", int'(rom_data), 0);
        chk("rst_core_reset", int'(core_reset), 1);
        chk("rst_load_done", int'(load_done), 0);
        chk("rst_load_err", int'(load_err), 0);
        reset_n = 1'b1;

        // Idle power-up with a user reset and stray strobes in EMPTY.
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_sys);
            user_reset = (i == 500);
            dl_wr      = (i == 700);
            if (core_reset !== 1'b1) bad++;
        end
        dl_wr = 1'b0; user_reset = 1'b0;
        chk("idle_core_reset_low", bad, 0);
        chk("idle_load_done", int'(load_done), 0);
        chk("idle_load_err", int'(load_err), 0);
        chk("idle_wr_count", wr_count, 0);

        // Full contiguous image.
        wr_count = 0;
        do_load(PROM_E, -1, 1'b0);
        edges_to_release(n);
        chk("full_release_edges", n, HOLD_N);
        chk("full_load_done", int'(load_done), 1);
        chk("full_load_err", int'(load_err), 0);
        chk("full_wr_count", wr_count, PROM_E);

        // User reset from RUN, then a restart from hold count 100.
        @(negedge clk_sys) user_reset = 1'b1;
        edges_to_release(n);
        chk("user_reset_edges", n, HOLD_N);
        @(negedge clk_sys) user_reset = 1'b1;
        @(posedge clk_sys);
        #1 user_reset = 1'b0;
        repeat (100) @(posedge clk_sys);
        @(negedge clk_sys) user_reset = 1'b1;
        edges_to_release(n);
        chk("hold_restart_edges", n, HOLD_N);

        // Short image, one byte missing.
        do_load(PROM_E - 1, -1, 1'b0);
        @(posedge clk_sys); #1;
        chk("short_load_err", int'(load_err), 1);
        chk("short_load_done", int'(load_done), 0);
        bad = 0;
        repeat (300) begin
            @(negedge clk_sys);
            if (core_reset !== 1'b1) bad++;
        end
        chk("short_core_reset_low", bad, 0);

        // Address gap after 0x100.
        do_load(PROM_E - 1, 'h100, 1'b0);
        @(posedge clk_sys); #1;
        chk("gap_load_err", int'(load_err), 1);
        chk("gap_load_done", int'(load_done), 0);

        // One byte past the end: last strobe dropped.
        wr_count = 0;
        do_load(PROM_E + 1, -1, 1'b0);
        @(posedge clk_sys); #1;
        chk("ovf_load_err", int'(load_err), 1);
        chk("ovf_load_done", int'(load_done), 0);
        repeat (3) @(negedge clk_sys);
        chk("ovf_wr_count", wr_count, PROM_E);
        chk("ovf_core_reset", int'(core_reset), 1);

        // Reset mid-load, then a complete load ending on the final strobe.
        @(negedge clk_sys) dl_active = 1'b1;
        for (int i = 0; i < 'h500; i++) begin
            @(negedge clk_sys);
            dl_wr = 1'b1; dl_addr = 25'(i); dl_data = 8'(i) ^ 8'h5A;
            sb.push_back(mk(i));
        end
        @(negedge clk_sys);
        #3;
        reset_n = 1'b0; dl_wr = 1'b0; dl_active = 1'b0;
        #1;
        chk("midrst_core_reset", int'(core_reset), 1);
        chk("midrst_rom_wr", int'(rom_wr), 0);
        chk("midrst_sb_empty", sb.size(), 0);
        @(negedge clk_sys) reset_n = 1'b1;
        repeat (20) @(negedge clk_sys);
        chk("midrst_still_reset", int'(core_reset), 1);
        chk("midrst_load_done", int'(load_done), 0);
        wr_count = 0;
        do_load(PROM_E, -1, 1'b1);
        edges_to_release(n);
        chk("reload_release_edges", n, HOLD_N);
        chk("reload_load_done", int'(load_done), 1);
        chk("reload_load_err", int'(load_err), 0);
        chk("reload_wr_count", wr_count, PROM_E);
        chk("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
